input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage between the board buttons/switches and the 4x4 cell array.
- Synchronizes and debounces the fire, add and select-commit buttons, and produces single-cycle event pulses from them.
- Validates the 4-bit row/column switch bank as one-hot, then latches it into the registered one-hot row and column enables that the cell array consumes.
- Replaces the open switch-wiring / edge-detect work in the top level.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a button change is accepted (10 ms at 100 MHz); legal range >= 2.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers; legal range >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn_fire  input  1  raw fire button, active-high
- btn_addn  input  1  raw add/remove button, active-high
- btn_commit  input  1  raw button that commits the switch selection
- sw_sel  input  4  raw row/column switches
- sw_nrow  input  1  0 = commit writes row, 1 = commit writes column
- row  output  4  registered one-hot row enable; 0 = none selected
- col  output  4  registered one-hot column enable; 0 = none selected
- armed  output  1  high when row != 0 and col != 0
- fire_pulse  output  1  one-cycle fire event, gated by armed
- addn_pulse  output  1  one-cycle add/remove event, not gated
- sel_error  output  1  registered flag: synchronized sw_sel is not exactly one-hot

Behaviour:
- Reset (reset low, asynchronous): row, col, fire_pulse, addn_pulse, sel_error, armed = 0. All synchronizer flops, debouncer counters and debouncer stable states clear to 0.
- Synchronizers: every raw input passes through SYNC_STAGES flops; sw_sel and sw_nrow are synchronized bitwise.
- Debouncer, per button:
  - Holds `stable` and a counter sized ceil(log2(DEBOUNCE_CYCLES)).
  - If synced != stable: counter increments each cycle. When counter == DEBOUNCE_CYCLES-1, on the next edge stable <= synced and counter <= 0.
  - If synced == stable: counter <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
- Edge detect: rise = stable & ~stable_prev, registered. The output is exactly one cycle wide per accepted press. Releases produce no event.
- Latency: a raw button rise sampled at edge N gives a pulse high during cycle N + SYNC_STAGES + DEBOUNCE_CYCLES + 1.
- Holding a button produces one pulse only; the next pulse requires a debounced release followed by a new press.
- Selection validity (combinational on synced sw_sel): valid = popcount == 1. sel_error <= ~valid, registered each cycle.
- Commit: on commit pulse with valid high, row <= sw_sel_sync if sw_nrow_sync == 0, else col <= sw_sel_sync.
  - On commit with valid low, row and col hold.
  - Only one of row/col updates per commit.
- armed = (row != 0) && (col != 0), derived from the registered row/col.
- fire_pulse = internal fire rise & armed. The armed value used is the pre-update one, so a commit and a fire in the same cycle use the old row/col.
- Fire presses while unarmed are dropped, not queued.
- Simultaneous fire and addn pulses are both emitted in the same cycle; downstream resolves priority.
- reset asserted mid-debounce aborts the count; after release, no pulse is emitted for a button that was already held.

Decomposition:
- Shared package:
  - GRID_N = 4
  - DEBOUNCE_DEFAULT = 1_000_000
  - one-hot validity function (popcount == 1)
- Natural sub-module: `debounce_edge`, containing synchronizer + debouncer + rising-edge pulse. Instantiated three times (fire, addn, commit).
- Switch synchronization, validity check, row/col latch and fire gating stay in the parent.

Test Plan (DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2):
- Reset: hold reset low, toggle all inputs -> all outputs 0. Release reset -> row = col = 0, armed = 0.
- Clean press: btn_addn 0->1 at edge 10, held 20 cycles -> addn_pulse high in cycle 17 only. No pulse on release.
- Glitch: btn_fire high for 3 cycles, then low -> no fire_pulse, counter back to 0.
- Selection:
  - sw_sel = 4'b0100, sw_nrow = 0, press commit -> row = 4'b0100, col = 0, armed = 0.
  - sw_sel = 4'b0010, sw_nrow = 1, press commit -> col = 4'b0010, armed = 1.
  - sw_sel = 4'b0110 -> sel_error = 1 three cycles later; commit leaves row and col unchanged.
- Gating:
  - With row = 0, press fire -> no fire_pulse.
  - After arming, press fire -> single fire_pulse.
  - Fire and commit pulses in the same cycle while unarmed -> no fire_pulse.
- Async reset mid-debounce: btn_fire held, reset low at count 2, released while button still held -> no fire_pulse until a release and a new press.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the button/switch front end.
// Latency: n/a (package only).
// Backpressure: n/a.
package input_conditioner_pkg;

  localparam int GRID_N           = 4;
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  // A selection is usable only when exactly one switch is up.
  function automatic logic is_onehot(input logic [GRID_N-1:0] v);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < GRID_N; i++) begin
      ones += 32'(v[i]);
    end
    return (ones == 32'd1);
  endfunction

endpackage

// File: rtl/debounce_edge.sv
// Synchronizer + debouncer + registered rising-edge pulse for one button.
// Latency: raw rise at edge N -> rise high after edge N+SYNC_STAGES+DEBOUNCE_CYCLES.
// Backpressure: none; the button is sampled every cycle and pulses are never held.
//
// Ports:
//   clk, reset (async, active-low)
//   btn  : raw button, active-high
//   rise : one-cycle pulse per accepted press
module debounce_edge #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // After reset the synchronizer shows SYNC_STAGES cleared samples that say
  // nothing about the real button. Edge events are enabled only after the
  // button has been seen low for longer than that, so a button held through
  // reset cannot masquerade as a fresh press.
  localparam int PRIME_CYCLES = DEBOUNCE_CYCLES + SYNC_STAGES;
  localparam int PRIME_W      = $clog2(PRIME_CYCLES);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;
  logic                   stable;
  logic                   stable_prev;
  logic                   primed;
  logic [PRIME_W-1:0]     prime_cnt;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (synced != stable) begin
      if (cnt == CNT_LAST) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      primed    <= 1'b0;
      prime_cnt <= '0;
    end else if (!primed) begin
      if (synced) begin
        prime_cnt <= '0;
      end else if (prime_cnt == PRIME_LAST) begin
        primed <= 1'b1;
      end else begin
        prime_cnt <= prime_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_prev <= 1'b0;
      rise        <= 1'b0;
    end else begin
      stable_prev <= stable;
      rise        <= stable & ~stable_prev & primed;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Button/switch front end: debounced event pulses plus one-hot row/col latch.
// Latency: button rise at edge N -> pulse after edge N+SYNC_STAGES+DEBOUNCE_CYCLES.
// Backpressure: none; events are single-cycle and dropped if not consumed.
//
// Ports:
//   clk, reset (async, active-low)
//   btn_fire, btn_addn, btn_commit : raw active-high buttons
//   sw_sel[3:0], sw_nrow           : raw selection switches, 0 = write row, 1 = write col
//   row, col                       : registered one-hot enables (0 = none)
//   armed                          : row and col both selected
//   fire_pulse                     : fire event, only while armed
//   addn_pulse                     : add/remove event, ungated
//   sel_error                      : registered, synchronized sw_sel not one-hot
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_fire,
  input  logic              btn_addn,
  input  logic              btn_commit,
  input  logic [GRID_N-1:0] sw_sel,
  input  logic              sw_nrow,
  output logic [GRID_N-1:0] row,
  output logic [GRID_N-1:0] col,
  output logic              armed,
  output logic              fire_pulse,
  output logic              addn_pulse,
  output logic              sel_error
);

  logic fire_rise;
  logic addn_rise;
  logic commit_rise;

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_fire (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_fire),
    .rise (fire_rise)
  );

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_addn (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_addn),
    .rise (addn_rise)
  );

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_commit (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_commit),
    .rise (commit_rise)
  );

  // Switches are synchronized bitwise; {sw_nrow, sw_sel} travel together.
  logic [SYNC_STAGES-1:0][GRID_N:0] sw_sync_q;
  logic [GRID_N-1:0]                sel_sync;
  logic                             nrow_sync;
  logic                             sel_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_sync_q <= '0;
    end else begin
      sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], {sw_nrow, sw_sel}};
    end
  end

  assign sel_sync  = sw_sync_q[SYNC_STAGES-1][GRID_N-1:0];
  assign nrow_sync = sw_sync_q[SYNC_STAGES-1][GRID_N];
  assign sel_valid = is_onehot(sel_sync);

  // A commit with an invalid selection is ignored; only one of row/col moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row       <= '0;
      col       <= '0;
      sel_error <= 1'b0;
    end else begin
      sel_error <= ~sel_valid;
      if (commit_rise && sel_valid) begin
        if (!nrow_sync) begin
          row <= sel_sync;
        end else begin
          col <= sel_sync;
        end
      end
    end
  end

  assign armed = (row != '0) && (col != '0);

  // Gating uses the registered row/col, so a commit landing in the same cycle
  // as a fire does not arm that fire.
  assign fire_pulse = fire_rise & armed;
  assign addn_pulse = addn_rise;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int D    = 4;
  localparam int S    = 2;
  localparam int MAXE = 20000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_fire = 1'b0, btn_addn = 1'b0, btn_commit = 1'b0, sw_nrow = 1'b0;
  logic [3:0] sw_sel = 4'b0;
  logic [3:0] row, col;
  logic       armed, fire_pulse, addn_pulse, sel_error;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset_n),
    .btn_fire  (btn_fire),
    .btn_addn  (btn_addn),
    .btn_commit(btn_commit),
    .sw_sel    (sw_sel),
    .sw_nrow   (sw_nrow),
    .row       (row),
    .col       (col),
    .armed     (armed),
    .fire_pulse(fire_pulse),
    .addn_pulse(addn_pulse),
    .sel_error (sel_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, edge_cnt);
    end
  endtask

  // ---------------- reference model (sample-indexed) ----------------
  // Raw inputs are recorded per clock edge index. A level change of a button
  // is accepted at the sample where the last D samples all disagree with the
  // accepted level; its pulse appears S+1 edges later. The synchronized
  // switches seen at edge e are the raw ones sampled at edge e-S.
  typedef struct {
    int         e;
    logic [3:0] r;
    logic [3:0] c;
  } rc_t;

  bit         raw_hist [3][MAXE];
  logic [4:0] sw_hist  [MAXE];
  bit         mstable  [3];
  logic [3:0] m_row, m_col;
  int         exp_fire[$], exp_addn[$], pend_fire[$], pend_commit[$];
  rc_t        rc_q[$];
  logic [3:0] cur_row = 4'b0, cur_col = 4'b0;
  bit         mon_on = 1'b0;
  int         mon_start = 0;
  logic [3:0] sel_tbl [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0000, 4'b0110, 4'b1111, 4'b1001};

  function automatic bit window_all(input int b, input int last, input bit v);
    for (int i = last - D + 1; i <= last; i++) begin
      if (raw_hist[b][i] != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input int e, input int start);
    int         mc, mf, p;
    logic [4:0] sw;
    for (int b = 0; b < 3; b++) begin
      if (e - start >= D - 1 && window_all(b, e, ~mstable[b])) begin
        mstable[b] = ~mstable[b];
        if (mstable[b]) begin
          case (b)
            0:       pend_fire.push_back(e);
            1:       exp_addn.push_back(e + S + 1);
            default: pend_commit.push_back(e);
          endcase
        end
      end
    end
    // A commit pulse at edge p writes at edge p+1 using switches sampled at p+1-S.
    while (pend_commit.size() > 0 && pend_commit[0] + 2 <= e) begin
      mc = pend_commit.pop_front();
      p  = mc + S + 1;
      sw = sw_hist[p + 1 - S];
      if ($countones(sw[3:0]) == 1) begin
        if (sw[4]) m_col = sw[3:0];
        else       m_row = sw[3:0];
        rc_q.push_back('{p + 1, m_row, m_col});
      end
    end
    // A fire pulse at q sees only commits whose pulse came strictly earlier.
    while (pend_fire.size() > 0 && pend_fire[0] + 1 <= e) begin
      mf = pend_fire.pop_front();
      if (m_row != 4'b0 && m_col != 4'b0) exp_fire.push_back(mf + S + 1);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin : monitor
    int e;
    bit ef, ea;
    #1;
    if (mon_on && edge_cnt >= mon_start) begin
      e = edge_cnt;
      while (rc_q.size() > 0 && rc_q[0].e <= e) begin
        cur_row = rc_q[0].r;
        cur_col = rc_q[0].c;
        void'(rc_q.pop_front());
      end
      ef = (exp_fire.size() > 0 && exp_fire[0] == e);
      if (ef) void'(exp_fire.pop_front());
      ea = (exp_addn.size() > 0 && exp_addn[0] == e);
      if (ea) void'(exp_addn.pop_front());
      check("sb_row", row, cur_row);
      check("sb_col", col, cur_col);
      check("sb_armed", armed, (cur_row != 4'b0 && cur_col != 4'b0));
      check("sb_sel_error", sel_error, ($countones(sw_hist[e - S][3:0]) != 1));
      check("sb_fire_pulse", fire_pulse, ef);
      check("sb_addn_pulse", addn_pulse, ea);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic idle_inputs();
    btn_fire = 1'b0; btn_addn = 1'b0; btn_commit = 1'b0;
  endtask

  // Counts pulses over n cycles, sampled at falling edges; first = index of
  // the first falling edge (1-based) where addn_pulse was high.
  task automatic watch(input int n, output int first, output int na, output int nf);
    first = -1; na = 0; nf = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (addn_pulse) begin
        na++;
        if (first < 0) first = k;
      end
      if (fire_pulse) nf++;
    end
  endtask

  task automatic commit_sel(input logic [3:0] sel, input logic nrow);
    int f, na, nf;
    @(negedge clk);
    sw_sel = sel; sw_nrow = nrow; btn_commit = 1'b1;
    watch(10, f, na, nf);
    btn_commit = 1'b0;
    watch(10, f, na, nf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int  f, na, nf, na2, nf2, e, start;
    bit  lvl [3];
    int  hold [3];

    // Reset holds every output low whatever the inputs do.
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {btn_fire, btn_addn, btn_commit, sw_nrow} = 4'($urandom);
      sw_sel = 4'($urandom);
      @(posedge clk);
      #1;
      check("reset_outputs", {row, col, armed, fire_pulse, addn_pulse, sel_error}, 32'd0);
    end
    @(negedge clk);
    idle_inputs(); sw_sel = 4'b0; sw_nrow = 1'b0;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_row_col_armed", {row, col, armed}, 32'd0);

    // Clean press: one pulse, S+D+1 falling edges after the first sampling edge.
    btn_addn = 1'b1;
    watch(20, f, na, nf);
    check("press_latency", f, S + D + 1);
    check("press_single", na, 1);
    btn_addn = 1'b0;
    watch(15, f, na, nf);
    check("release_no_pulse", na, 0);

    // Glitch of D-1 cycles is discarded; exactly D cycles is accepted.
    btn_addn = 1'b1; btn_fire = 1'b1;
    watch(D - 1, f, na, nf);
    idle_inputs();
    watch(12, f, na2, nf2);
    check("glitch_addn", na + na2, 0);
    check("glitch_fire", nf + nf2, 0);
    btn_addn = 1'b1;
    watch(D, f, na, nf);
    idle_inputs();
    watch(12, f, na2, nf2);
    check("min_hold_addn", na + na2, 1);

    // Fire while unarmed is dropped.
    btn_fire = 1'b1;
    watch(15, f, na, nf);
    btn_fire = 1'b0;
    watch(12, f, na, nf2);
    check("unarmed_fire", nf + nf2, 0);

    // Selection.
    commit_sel(4'b0100, 1'b0);
    check("sel_row", row, 4'b0100);
    check("sel_row_col", col, 4'b0000);
    check("sel_row_armed", armed, 1'b0);
    commit_sel(4'b0010, 1'b1);
    check("sel_col", col, 4'b0010);
    check("sel_col_row", row, 4'b0100);
    check("sel_col_armed", armed, 1'b1);

    // Armed fire gives exactly one pulse.
    btn_fire = 1'b1;
    watch(15, f, na, nf);
    btn_fire = 1'b0;
    watch(12, f, na, nf2);
    check("armed_fire_single", nf + nf2, 1);

    // Invalid selection flags three cycles later, and commit is ignored.
    @(negedge clk);
    sw_sel = 4'b0110; sw_nrow = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sel_error_early", sel_error, 1'b0);
    @(negedge clk);
    check("sel_error_set", sel_error, 1'b1);
    commit_sel(4'b0110, 1'b0);
    check("bad_commit_row", row, 4'b0100);
    check("bad_commit_col", col, 4'b0010);

    // Fire and commit in the same cycle while unarmed: fire is dropped.
    do_reset();
    commit_sel(4'b0100, 1'b0);
    @(negedge clk);
    sw_sel = 4'b0010; sw_nrow = 1'b1;
    btn_fire = 1'b1; btn_commit = 1'b1;
    watch(15, f, na, nf);
    idle_inputs();
    watch(12, f, na, nf2);
    check("same_cycle_fire", nf + nf2, 0);
    check("same_cycle_armed", armed, 1'b1);
    check("same_cycle_col", col, 4'b0010);

    // Asynchronous reset part way through a debounce, button still held.
    @(negedge clk);
    btn_addn = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_row_col", {row, col, armed}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    watch(25, f, na, nf);
    check("held_through_reset", na, 0);
    btn_addn = 1'b0;
    watch(15, f, na, nf);
    check("held_release", na, 0);
    btn_addn = 1'b1;
    watch(20, f, na, nf);
    check("repress_latency", f, S + D + 1);
    check("repress_single", na, 1);
    btn_addn = 1'b0;
    watch(12, f, na, nf);

    // Randomized run checked by the scoreboard.
    do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sw_sel = 4'b0001; sw_nrow = 1'b0;
    m_row = 4'b0; m_col = 4'b0; cur_row = 4'b0; cur_col = 4'b0;
    for (int b = 0; b < 3; b++) begin
      mstable[b] = 1'b0; lvl[b] = 1'b0; hold[b] = 0;
    end
    start = -1;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      e = edge_cnt + 1;
      if (start < 0) begin
        start     = e;
        mon_start = start + 10;
        mon_on    = 1'b1;
      end
      if (i < 20 || i >= 3250) begin
        for (int b = 0; b < 3; b++) lvl[b] = 1'b0;
      end else begin
        for (int b = 0; b < 3; b++) begin
          if (hold[b] == 0) begin
            lvl[b]  = ~lvl[b];
            hold[b] = $urandom_range(1, 9);
          end else begin
            hold[b]--;
          end
        end
        if ($urandom_range(0, 11) == 0) begin
          sw_sel  = sel_tbl[$urandom_range(0, 7)];
          sw_nrow = 1'($urandom_range(0, 1));
        end
      end
      btn_fire = lvl[0]; btn_addn = lvl[1]; btn_commit = lvl[2];
      raw_hist[0][e] = lvl[0];
      raw_hist[1][e] = lvl[1];
      raw_hist[2][e] = lvl[2];
      sw_hist[e]     = {sw_nrow, sw_sel};
      model_step(e, start);
    end
    @(negedge clk);
    mon_on = 1'b0;
    check("drain_fire_queue", exp_fire.size(), 0);
    check("drain_addn_queue", exp_addn.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
